// File: rtl/menshen_h2c_cfg_arbiter.sv
// rtl/menshen_h2c_cfg_arbiter.sv - packet-atomic 2:1 H2C stream arbiter, config priority with burst limit
// Optional drain state before a config packet that follows data: define CFG_ARB_QUIESCE_EN.
module menshen_h2c_cfg_arbiter #(
  parameter int DATA_WIDTH     = 512,
  parameter int MTY_WIDTH      = 6,
  parameter int MAX_CFG_BURST  = 4,
  parameter int QUIESCE_CYCLES = 8
) (
  input  logic                  axis_aclk,
  input  logic                  axis_rst,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic [MTY_WIDTH-1:0]  s_axis_data_tuser_mty,
  input  logic [31:0]           s_axis_data_tuser_mdata,
  input  logic                  s_axis_data_tvalid,
  input  logic                  s_axis_data_tlast,
  output logic                  s_axis_data_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_cfg_tdata,
  input  logic [MTY_WIDTH-1:0]  s_axis_cfg_tuser_mty,
  input  logic [31:0]           s_axis_cfg_tuser_mdata,
  input  logic                  s_axis_cfg_tvalid,
  input  logic                  s_axis_cfg_tlast,
  output logic                  s_axis_cfg_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [MTY_WIDTH-1:0]  m_axis_tuser_mty,
  output logic [31:0]           m_axis_tuser_mdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  cfg_busy,
  output logic [15:0]           cfg_pkt_cnt
);

  if ((DATA_WIDTH % 8) != 0 || MTY_WIDTH != $clog2(DATA_WIDTH / 8) ||
      MAX_CFG_BURST < 1 || MAX_CFG_BURST > 255 ||
      QUIESCE_CYCLES < 1 || QUIESCE_CYCLES > 255) begin : g_bad_params
    $error("menshen_h2c_cfg_arbiter: parameter out of range");
  end

  localparam logic [7:0] MAX_BURST = 8'(MAX_CFG_BURST);

`ifdef CFG_ARB_QUIESCE_EN
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GRANT_DATA = 2'd1,
    S_GRANT_CFG  = 2'd2,
    S_QUIESCE    = 2'd3
  } state_t;

  // The mandatory IDLE bubble is the first dead cycle, so QUIESCE itself lasts one less.
  localparam logic [7:0] QUIESCE_LOAD = 8'(QUIESCE_CYCLES - 1);
  logic [7:0] quiesce_cnt;
  logic       last_was_data;
`else
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GRANT_DATA = 2'd1,
    S_GRANT_CFG  = 2'd2
  } state_t;
`endif

  state_t     state;
  logic       grant_data;
  logic       grant_cfg;
  logic [7:0] burst_cnt;
  logic       burst_ok;
  logic       cfg_wins;
  logic       data_last_xfer;
  logic       cfg_last_xfer;

  assign burst_ok = burst_cnt < MAX_BURST;
  assign cfg_wins = s_axis_cfg_tvalid && (burst_ok || !s_axis_data_tvalid);

  assign m_axis_tvalid      = (grant_data && s_axis_data_tvalid) || (grant_cfg && s_axis_cfg_tvalid);
  assign m_axis_tdata       = grant_cfg ? s_axis_cfg_tdata :
                              grant_data ? s_axis_data_tdata : '0;
  assign m_axis_tuser_mty   = grant_cfg ? s_axis_cfg_tuser_mty :
                              grant_data ? s_axis_data_tuser_mty : '0;
  assign m_axis_tuser_mdata = grant_cfg ? s_axis_cfg_tuser_mdata :
                              grant_data ? s_axis_data_tuser_mdata : '0;
  assign m_axis_tlast       = grant_cfg ? s_axis_cfg_tlast :
                              grant_data ? s_axis_data_tlast : 1'b0;

  assign s_axis_data_tready = grant_data && m_axis_tready;
  assign s_axis_cfg_tready  = grant_cfg && m_axis_tready;
  assign cfg_busy           = grant_cfg;

  assign data_last_xfer = grant_data && s_axis_data_tvalid && s_axis_data_tlast && m_axis_tready;
  assign cfg_last_xfer  = grant_cfg && s_axis_cfg_tvalid && s_axis_cfg_tlast && m_axis_tready;

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state       <= S_IDLE;
      grant_data  <= 1'b0;
      grant_cfg   <= 1'b0;
      burst_cnt   <= 8'd0;
      cfg_pkt_cnt <= 16'd0;
`ifdef CFG_ARB_QUIESCE_EN
      quiesce_cnt   <= 8'd0;
      last_was_data <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_wins) begin
`ifdef CFG_ARB_QUIESCE_EN
            if (last_was_data) begin
              state       <= S_QUIESCE;
              quiesce_cnt <= QUIESCE_LOAD;
            end else begin
              state     <= S_GRANT_CFG;
              grant_cfg <= 1'b1;
            end
`else
            state     <= S_GRANT_CFG;
            grant_cfg <= 1'b1;
`endif
          end else if (s_axis_data_tvalid) begin
            state      <= S_GRANT_DATA;
            grant_data <= 1'b1;
          end
        end
        S_GRANT_DATA: begin
          if (data_last_xfer) begin
            state      <= S_IDLE;
            grant_data <= 1'b0;
            burst_cnt  <= 8'd0;
`ifdef CFG_ARB_QUIESCE_EN
            last_was_data <= 1'b1;
`endif
          end
        end
        S_GRANT_CFG: begin
          if (cfg_last_xfer) begin
            state       <= S_IDLE;
            grant_cfg   <= 1'b0;
            cfg_pkt_cnt <= cfg_pkt_cnt + 16'd1;
            if (burst_ok) begin
              burst_cnt <= burst_cnt + 8'd1;
            end
`ifdef CFG_ARB_QUIESCE_EN
            last_was_data <= 1'b0;
`endif
          end
        end
`ifdef CFG_ARB_QUIESCE_EN
        S_QUIESCE: begin
          if (quiesce_cnt <= 8'd1) begin
            state       <= S_GRANT_CFG;
            grant_cfg   <= 1'b1;
            quiesce_cnt <= 8'd0;
          end else begin
            quiesce_cnt <= quiesce_cnt - 8'd1;
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          grant_data <= 1'b0;
          grant_cfg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_menshen_h2c_cfg_arbiter.sv
// tb/tb_menshen_h2c_cfg_arbiter.sv - self-checking bench for menshen_h2c_cfg_arbiter
// Cycle vectors, hand sequences, and randomized traffic checked by a packet-level scoreboard.
module tb_menshen_h2c_cfg_arbiter;
  localparam int DW   = 512;
  localparam int MW   = 6;
  localparam int MAXB = 4;
  localparam logic [DW-1:0] D_PAT = {8{64'h0801_0203_0405_0609}};
  localparam logic [DW-1:0] C_PAT = {16{32'hC0FF_EE4A}};

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data_tdata, s_cfg_tdata, m_tdata;
  logic [MW-1:0] s_data_mty, s_cfg_mty, m_mty;
  logic [31:0]   s_data_mdata, s_cfg_mdata, m_mdata;
  logic          s_data_tvalid, s_data_tlast, s_data_tready;
  logic          s_cfg_tvalid, s_cfg_tlast, s_cfg_tready;
  logic          m_tvalid, m_tlast, m_tready, cfg_busy;
  logic [15:0]   cfg_pkt_cnt;

  always #5 clk = ~clk;

  menshen_h2c_cfg_arbiter #(
    .DATA_WIDTH(DW), .MTY_WIDTH(MW), .MAX_CFG_BURST(MAXB), .QUIESCE_CYCLES(8)
  ) dut (
    .axis_aclk(clk), .axis_rst(rst),
    .s_axis_data_tdata(s_data_tdata), .s_axis_data_tuser_mty(s_data_mty),
    .s_axis_data_tuser_mdata(s_data_mdata), .s_axis_data_tvalid(s_data_tvalid),
    .s_axis_data_tlast(s_data_tlast), .s_axis_data_tready(s_data_tready),
    .s_axis_cfg_tdata(s_cfg_tdata), .s_axis_cfg_tuser_mty(s_cfg_mty),
    .s_axis_cfg_tuser_mdata(s_cfg_mdata), .s_axis_cfg_tvalid(s_cfg_tvalid),
    .s_axis_cfg_tlast(s_cfg_tlast), .s_axis_cfg_tready(s_cfg_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser_mty(m_mty), .m_axis_tuser_mdata(m_mdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .cfg_busy(cfg_busy), .cfg_pkt_cnt(cfg_pkt_cnt)
  );

  typedef struct {
    logic [DW-1:0] tdata;
    logic [MW-1:0] mty;
    logic [31:0]   mdata;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    logic dv, dl, cv, cl, mr;
    logic e_mv, e_dr, e_cr, e_busy;
    int   e_src;
  } vec_t;

  int    n_checks, n_pass;
  beat_t dq[$], cq[$], exp_dq[$], exp_cq[$];
  int    order_q[$];
  vec_t  vecs[13];
  bit    auto_en, in_pkt, prev_dv, prev_cv, fire_d, fire_c;
  int    cyc, pkt_src, run, last_tlast_cyc, cfg_done, d_gap, c_gap, ready_mode;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic add_pkt(input bit is_cfg, input int len, input int gap0, input int max_igap);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.tdata = rand_wide();
      b.last  = (i == len - 1);
      b.mty   = b.last ? MW'($urandom_range(0, 63)) : '0;
      b.mdata = {is_cfg, 31'($urandom())};
      b.gap   = (i == 0) ? gap0 : $urandom_range(0, max_igap);
      if (is_cfg) begin cq.push_back(b); exp_cq.push_back(b); end
      else begin dq.push_back(b); exp_dq.push_back(b); end
    end
  endtask

  // Packet-level scoreboard: arbitration choice, atomicity, bubble, content, grant-side outputs.
  task automatic monitor();
    bit gc, gd;
    int exp_src;
    beat_t b;
    if (!in_pkt && m_tvalid) begin
      exp_src = (prev_cv && (run < MAXB || !prev_dv)) ? 1 : (prev_dv ? 0 : 2);
      chk("arb_choice", int'(m_mdata[31]), exp_src);
      chk("idle_bubble", int'((cyc - last_tlast_cyc) >= 2), 1);
      in_pkt  = 1'b1;
      pkt_src = int'(m_mdata[31]);
    end
    gc = in_pkt && (pkt_src == 1);
    gd = in_pkt && (pkt_src == 0);
    chk("cfg_busy", int'(cfg_busy), int'(gc));
    chk("s_cfg_tready", int'(s_cfg_tready), int'(gc && m_tready));
    chk("s_data_tready", int'(s_data_tready), int'(gd && m_tready));
    chk("m_tvalid", int'(m_tvalid), int'((gc && s_cfg_tvalid) || (gd && s_data_tvalid)));
    if (in_pkt && m_tvalid && m_tready) begin
      chk("no_interleave", int'(m_mdata[31]), pkt_src);
      if ((pkt_src == 1 && exp_cq.size() == 0) || (pkt_src == 0 && exp_dq.size() == 0)) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        b = (pkt_src == 1) ? exp_cq.pop_front() : exp_dq.pop_front();
        chk_w("beat_tdata", m_tdata, b.tdata);
        chk("beat_mty", int'(m_mty), int'(b.mty));
        chk("beat_mdata", int'(m_mdata), int'(b.mdata));
        chk("beat_tlast", int'(m_tlast), int'(b.last));
      end
      if (m_tlast) begin
        in_pkt = 1'b0;
        last_tlast_cyc = cyc;
        order_q.push_back(pkt_src);
        if (pkt_src == 1) begin
          cfg_done++;
          if (run < MAXB) run++;
        end else begin
          run = 0;
        end
      end
    end
    prev_dv = s_data_tvalid;
    prev_cv = s_cfg_tvalid;
  endtask

  task automatic drive();
    if (fire_d) begin
      void'(dq.pop_front());
      if (dq.size() != 0) d_gap = dq[0].gap;
    end
    if (fire_c) begin
      void'(cq.pop_front());
      if (cq.size() != 0) c_gap = cq[0].gap;
    end
    if (d_gap > 0) begin s_data_tvalid = 1'b0; d_gap--; end
    else if (dq.size() != 0) begin
      s_data_tvalid = 1'b1; s_data_tdata = dq[0].tdata; s_data_mty = dq[0].mty;
      s_data_mdata = dq[0].mdata; s_data_tlast = dq[0].last;
    end else s_data_tvalid = 1'b0;
    if (c_gap > 0) begin s_cfg_tvalid = 1'b0; c_gap--; end
    else if (cq.size() != 0) begin
      s_cfg_tvalid = 1'b1; s_cfg_tdata = cq[0].tdata; s_cfg_mty = cq[0].mty;
      s_cfg_mdata = cq[0].mdata; s_cfg_tlast = cq[0].last;
    end else s_cfg_tvalid = 1'b0;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    if (auto_en) monitor();
    fire_d = s_data_tvalid && s_data_tready;
    fire_c = s_cfg_tvalid && s_cfg_tready;
    @(posedge clk); #1;
    cyc++;
    if (auto_en) drive();
  endtask

  task automatic do_reset();
    auto_en = 1'b0; rst = 1'b1; s_data_tvalid = 1'b0; s_cfg_tvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    in_pkt = 1'b0; run = 0; cfg_done = 0; last_tlast_cyc = cyc - 10;
    prev_dv = 1'b0; prev_cv = 1'b0; fire_d = 1'b0; fire_c = 1'b0;
    order_q.delete();
  endtask

  task automatic run_auto(input int mode, input int budget);
    int n;
    ready_mode = mode;
    m_tready = (mode == 1) ? 1'b0 : 1'b1;
    d_gap = (dq.size() != 0) ? dq[0].gap : 0;
    c_gap = (cq.size() != 0) ? cq[0].gap : 0;
    auto_en = 1'b1;
    drive();
    n = 0;
    while ((dq.size() != 0 || cq.size() != 0 || exp_dq.size() != 0 ||
            exp_cq.size() != 0 || in_pkt) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", n, -1);
    repeat (3) step();
  endtask

  initial begin
    int exp_order[9];
    n_checks = 0; n_pass = 0; cyc = 0; auto_en = 1'b0; ready_mode = 0;
    rst = 1'b1; m_tready = 1'b1;
    s_data_tvalid = 1'b0; s_data_tlast = 1'b0; s_cfg_tvalid = 1'b0; s_cfg_tlast = 1'b0;
    s_data_tdata = D_PAT; s_data_mty = '0; s_data_mdata = 32'h11;
    s_cfg_tdata = C_PAT; s_cfg_mty = 6'd5; s_cfg_mdata = 32'h4A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_s_data_tready", int'(s_data_tready), 0);
    chk("rst_s_cfg_tready", int'(s_cfg_tready), 0);
    chk("rst_cfg_busy", int'(cfg_busy), 0);
    chk("rst_cfg_pkt_cnt", int'(cfg_pkt_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    //           dv dl cv cl mr  mv dr cr busy src
    vecs[0]  = '{1, 1, 0, 0, 1,  0, 0, 0, 0,  0};
    vecs[1]  = '{1, 1, 0, 0, 1,  1, 1, 0, 0,  1};
    vecs[2]  = '{1, 0, 1, 1, 1,  0, 0, 0, 0,  0};
    vecs[3]  = '{1, 0, 1, 1, 0,  1, 0, 0, 1,  2};
    vecs[4]  = '{1, 0, 1, 1, 1,  1, 0, 1, 1,  2};
    vecs[5]  = '{1, 0, 0, 0, 1,  0, 0, 0, 0,  0};
    vecs[6]  = '{1, 0, 1, 1, 1,  1, 1, 0, 0,  1};
    vecs[7]  = '{0, 0, 1, 1, 1,  0, 1, 0, 0,  1};
    vecs[8]  = '{1, 1, 1, 1, 1,  1, 1, 0, 0,  1};
    vecs[9]  = '{0, 0, 1, 1, 1,  0, 0, 0, 0,  0};
    vecs[10] = '{0, 0, 1, 1, 1,  1, 0, 1, 1,  2};
    vecs[11] = '{0, 0, 0, 0, 1,  0, 0, 0, 0,  0};
    vecs[12] = '{0, 0, 0, 0, 1,  0, 0, 0, 0,  0};

    for (int i = 0; i < 13; i++) begin
      s_data_tvalid = vecs[i].dv; s_data_tlast = vecs[i].dl;
      s_cfg_tvalid  = vecs[i].cv; s_cfg_tlast  = vecs[i].cl;
      m_tready      = vecs[i].mr;
      @(negedge clk);
      chk($sformatf("v%0d_m_tvalid", i), int'(m_tvalid), int'(vecs[i].e_mv));
      chk($sformatf("v%0d_s_data_tready", i), int'(s_data_tready), int'(vecs[i].e_dr));
      chk($sformatf("v%0d_s_cfg_tready", i), int'(s_cfg_tready), int'(vecs[i].e_cr));
      chk($sformatf("v%0d_cfg_busy", i), int'(cfg_busy), int'(vecs[i].e_busy));
      if (vecs[i].e_src == 1) begin
        chk_w($sformatf("v%0d_tdata", i), m_tdata, D_PAT);
        chk($sformatf("v%0d_mty", i), int'(m_mty), 0);
        chk($sformatf("v%0d_mdata", i), int'(m_mdata), 32'h11);
        chk($sformatf("v%0d_tlast", i), int'(m_tlast), int'(vecs[i].dl));
      end else if (vecs[i].e_src == 2) begin
        chk_w($sformatf("v%0d_tdata", i), m_tdata, C_PAT);
        chk($sformatf("v%0d_mty", i), int'(m_mty), 5);
        chk($sformatf("v%0d_mdata", i), int'(m_mdata), 32'h4A);
        chk($sformatf("v%0d_tlast", i), int'(m_tlast), int'(vecs[i].cl));
      end
      @(posedge clk); #1;
    end
    chk("table_cfg_pkt_cnt", int'(cfg_pkt_cnt), 2);

    // Reset while a data packet holds the grant.
    s_data_tvalid = 1'b1; s_data_tlast = 1'b0; s_cfg_tvalid = 1'b0; m_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_granted", int'(s_data_tready), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_s_data_tready", int'(s_data_tready), 0);
    chk("midrst_m_tvalid", int'(m_tvalid), 0);
    chk("midrst_cfg_pkt_cnt", int'(cfg_pkt_cnt), 0);
    @(posedge clk); #1;

    // Six config packets against continuously pending data.
    do_reset();
    for (int i = 0; i < 6; i++) add_pkt(1'b1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add_pkt(1'b0, 1, 0, 0);
    run_auto(0, 200);
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 0, 0};
    chk("burst_order_len", order_q.size(), 9);
    for (int i = 0; i < 9 && i < order_q.size(); i++)
      chk($sformatf("burst_order_%0d", i), order_q[i], exp_order[i]);
    chk("burst_cfg_pkt_cnt", int'(cfg_pkt_cnt), 6);

    // Four-beat config packet under alternating m_axis_tready, data waiting.
    do_reset();
    add_pkt(1'b1, 4, 0, 0);
    add_pkt(1'b0, 2, 0, 0);
    run_auto(1, 200);
    chk("toggle_first_is_cfg", (order_q.size() != 0) ? order_q[0] : -1, 1);
    chk("toggle_cfg_pkt_cnt", int'(cfg_pkt_cnt), 1);

    // Randomized traffic with gaps and backpressure.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      add_pkt(1'b0, $urandom_range(1, 4), $urandom_range(0, 3), 1);
      add_pkt(1'b1, $urandom_range(1, 3), $urandom_range(0, 3), 1);
    end
    run_auto(2, 6000);
    chk("rand_cfg_done", cfg_done, 24);
    chk("rand_cfg_pkt_cnt", int'(cfg_pkt_cnt), 24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
